// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and hazard_stall_ctrl.
// Perf_StallCnt exists only when HAZARD_PERF_EN is defined.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       D_Rs;
  logic [4:0]       D_Rt;
  logic [1:0]       D_TuseRs;
  logic [1:0]       D_TuseRt;
  logic             D_IsMD;
  logic [4:0]       E_A3;
  logic [4:0]       M_A3;
  logic             E_RegWrite;
  logic             M_RegWrite;
  logic [1:0]       E_Tnew;
  logic [1:0]       M_Tnew;
  logic             E_MDStart;
  logic             E_MDIsDiv;
  logic             Req;
  logic             Stall;
  logic             MD_Busy;
  logic [CNT_W-1:0] MD_Count;
  // Debug view of the MDU countdown FSM: 1 = BUSY, 0 = IDLE.
  logic             MD_State;
`ifdef HAZARD_PERF_EN
  logic [31:0]      Perf_StallCnt;
`endif

  modport master (
    output D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_IsMD,
    output E_A3, M_A3, E_RegWrite, M_RegWrite, E_Tnew, M_Tnew,
    output E_MDStart, E_MDIsDiv, Req,
`ifdef HAZARD_PERF_EN
    input  Perf_StallCnt,
`endif
    input  Stall, MD_Busy, MD_Count, MD_State
  );

  modport slave (
    input  D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_IsMD,
    input  E_A3, M_A3, E_RegWrite, M_RegWrite, E_Tnew, M_Tnew,
    input  E_MDStart, E_MDIsDiv, Req,
`ifdef HAZARD_PERF_EN
    output Perf_StallCnt,
`endif
    output Stall, MD_Busy, MD_Count, MD_State
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Tuse/Tnew stall detection plus MDU busy countdown for the 5-stage pipeline.
// Optional saturating stall counter enabled by defining HAZARD_PERF_EN.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_load_val;
  logic             w_start;
  logic             w_stall_rs;
  logic             w_stall_rt;
  logic             w_stall_md;
  logic             w_md_busy;
  logic             w_stall;

  // Register $0 is hard-wired to zero, so it can never be a real dependency.
  assign w_stall_rs = (bus.D_Rs != 5'd0) &&
                      ((bus.E_RegWrite && (bus.E_A3 == bus.D_Rs) && (bus.D_TuseRs < bus.E_Tnew)) ||
                       (bus.M_RegWrite && (bus.M_A3 == bus.D_Rs) && (bus.D_TuseRs < bus.M_Tnew)));
  assign w_stall_rt = (bus.D_Rt != 5'd0) &&
                      ((bus.E_RegWrite && (bus.E_A3 == bus.D_Rt) && (bus.D_TuseRt < bus.E_Tnew)) ||
                       (bus.M_RegWrite && (bus.M_A3 == bus.D_Rt) && (bus.D_TuseRt < bus.M_Tnew)));

  assign w_start    = bus.E_MDStart && !bus.Req;
  assign w_load_val = bus.E_MDIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Busy includes the start cycle itself; held low while reset is asserted.
  assign w_md_busy  = reset_n && ((r_count != '0) || w_start);
  assign w_stall_md = bus.D_IsMD && w_md_busy;
  assign w_stall    = (w_stall_rs || w_stall_rt || w_stall_md) && !bus.Req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_count_nxt = w_load_val;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_start) begin
          w_count_nxt = w_load_val;
          w_state_nxt = S_BUSY;
        end else if (r_count <= CNT_W'(1)) begin
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.Stall    = w_stall;
  assign bus.MD_Busy  = w_md_busy;
  assign bus.MD_Count = r_count;
  assign bus.MD_State = (r_state == S_BUSY);

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_cnt <= '0;
    end else if (w_stall && (r_perf_cnt != 32'hFFFF_FFFF)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign bus.Perf_StallCnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl; inputs change on the falling
// edge and outputs are sampled 1 ns later, away from the rising edge.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;

  logic clk;
  logic reset_n;
  int   num_checks;
  int   num_fail;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.D_Rs       = 5'd0;
    bus.D_Rt       = 5'd0;
    bus.D_TuseRs   = 2'd3;
    bus.D_TuseRt   = 2'd3;
    bus.D_IsMD     = 1'b0;
    bus.E_A3       = 5'd0;
    bus.M_A3       = 5'd0;
    bus.E_RegWrite = 1'b0;
    bus.M_RegWrite = 1'b0;
    bus.E_Tnew     = 2'd0;
    bus.M_Tnew     = 2'd0;
    bus.E_MDStart  = 1'b0;
    bus.E_MDIsDiv  = 1'b0;
    bus.Req        = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    #1;
    num_checks++;
    if (bus.MD_Count !== 4'd0) begin
      num_fail++; $display("FAIL reset_count: got %0d expected 0", bus.MD_Count);
    end
    num_checks++;
    if (bus.MD_Busy !== 1'b0 || bus.Stall !== 1'b0) begin
      num_fail++; $display("FAIL reset_outputs: busy=%b stall=%b expected 0 0", bus.MD_Busy, bus.Stall);
    end
    // Start request during reset must not show busy; data hazards still stall.
    bus.E_MDStart = 1'b1; bus.D_IsMD = 1'b1;
    bus.E_RegWrite = 1'b1; bus.E_A3 = 5'd4; bus.E_Tnew = 2'd1;
    bus.D_Rs = 5'd4; bus.D_TuseRs = 2'd0;
    #1;
    num_checks++;
    if (bus.MD_Busy !== 1'b0 || bus.Stall !== 1'b1) begin
      num_fail++; $display("FAIL reset_hazard: busy=%b stall=%b expected 0 1", bus.MD_Busy, bus.Stall);
    end
    @(negedge clk);
    drive_idle();
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    num_checks++;
    if (bus.MD_Count !== 4'd0 || bus.MD_State !== 1'b0) begin
      num_fail++; $display("FAIL reset_release: count=%0d state=%b expected 0 0", bus.MD_Count, bus.MD_State);
    end
  endtask

  task automatic test_data_hazard();
    // lw $8 in E, add in D reads $8 next cycle.
    @(negedge clk);
    drive_idle();
    bus.E_RegWrite = 1'b1; bus.E_A3 = 5'd8; bus.E_Tnew = 2'd2;
    bus.D_Rs = 5'd8; bus.D_TuseRs = 2'd1;
    #1;
    num_checks++;
    if (bus.Stall !== 1'b1) begin
      num_fail++; $display("FAIL lw_use_stall: got %b expected 1", bus.Stall);
    end
    @(negedge clk);
    bus.E_Tnew = 2'd0;
    #1;
    num_checks++;
    if (bus.Stall !== 1'b0) begin
      num_fail++; $display("FAIL lw_use_resolved: got %b expected 0", bus.Stall);
    end
    // M-stage producer on rt, Tuse 0 < Tnew 1.
    @(negedge clk);
    drive_idle();
    bus.M_RegWrite = 1'b1; bus.M_A3 = 5'd9; bus.M_Tnew = 2'd1;
    bus.D_Rt = 5'd9; bus.D_TuseRt = 2'd0;
    #1;
    num_checks++;
    if (bus.Stall !== 1'b1) begin
      num_fail++; $display("FAIL m_rt_stall: got %b expected 1", bus.Stall);
    end
    bus.D_TuseRt = 2'd1;
    #1;
    num_checks++;
    if (bus.Stall !== 1'b0) begin
      num_fail++; $display("FAIL m_rt_equal_tuse: got %b expected 0", bus.Stall);
    end
    // Tuse=3 (unused) never stalls even against Tnew=3.
    bus.M_Tnew = 2'd3; bus.D_TuseRt = 2'd3;
    #1;
    num_checks++;
    if (bus.Stall !== 1'b0) begin
      num_fail++; $display("FAIL tuse3_no_stall: got %b expected 0", bus.Stall);
    end
    // Producer without RegWrite is not a hazard.
    bus.D_TuseRt = 2'd0; bus.M_RegWrite = 1'b0;
    #1;
    num_checks++;
    if (bus.Stall !== 1'b0) begin
      num_fail++; $display("FAIL no_regwrite: got %b expected 0", bus.Stall);
    end
    // Req overrides a genuine hazard.
    bus.M_RegWrite = 1'b1; bus.Req = 1'b1;
    #1;
    num_checks++;
    if (bus.Stall !== 1'b0) begin
      num_fail++; $display("FAIL req_masks_stall: got %b expected 0", bus.Stall);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive_idle();
    bus.E_RegWrite = 1'b1; bus.E_A3 = 5'd0; bus.E_Tnew = 2'd2;
    bus.D_Rs = 5'd0; bus.D_TuseRs = 2'd0;
    bus.D_Rt = 5'd0; bus.D_TuseRt = 2'd0;
    #1;
    num_checks++;
    if (bus.Stall !== 1'b0) begin
      num_fail++; $display("FAIL zero_reg: got %b expected 0", bus.Stall);
    end
  endtask

  task automatic test_mult_countdown();
    @(negedge clk);
    drive_idle();
    bus.E_MDStart = 1'b1; bus.E_MDIsDiv = 1'b0; bus.D_IsMD = 1'b1;
    #1;
    num_checks++;
    if (bus.MD_Busy !== 1'b1 || bus.Stall !== 1'b1 || bus.MD_Count !== 4'd0) begin
      num_fail++; $display("FAIL mult_start: busy=%b stall=%b count=%0d expected 1 1 0",
                           bus.MD_Busy, bus.Stall, bus.MD_Count);
    end
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      bus.E_MDStart = 1'b0;
      #1;
      num_checks++;
      if (bus.MD_Count !== 4'(i) || bus.Stall !== (i != 0) || bus.MD_Busy !== (i != 0)) begin
        num_fail++; $display("FAIL mult_count_%0d: count=%0d stall=%b busy=%b expected %0d %b %b",
                             i, bus.MD_Count, bus.Stall, bus.MD_Busy, i, (i != 0), (i != 0));
      end
    end
  endtask

  task automatic test_req_blocks_start();
    @(negedge clk);
    drive_idle();
    bus.E_MDStart = 1'b1; bus.E_MDIsDiv = 1'b1; bus.Req = 1'b1; bus.D_IsMD = 1'b1;
    #1;
    num_checks++;
    if (bus.MD_Busy !== 1'b0 || bus.Stall !== 1'b0) begin
      num_fail++; $display("FAIL req_start_comb: busy=%b stall=%b expected 0 0", bus.MD_Busy, bus.Stall);
    end
    @(negedge clk);
    drive_idle();
    #1;
    num_checks++;
    if (bus.MD_Count !== 4'd0) begin
      num_fail++; $display("FAIL req_start_count: got %0d expected 0", bus.MD_Count);
    end
  endtask

  task automatic test_back_to_back();
    // Mult running, then a div start while busy reloads to 10.
    @(negedge clk);
    drive_idle();
    bus.E_MDStart = 1'b1; bus.E_MDIsDiv = 1'b0;
    @(negedge clk);
    bus.E_MDStart = 1'b0;
    @(negedge clk);
    #1;
    num_checks++;
    if (bus.MD_Count !== 4'd4) begin
      num_fail++; $display("FAIL b2b_mult: got %0d expected 4", bus.MD_Count);
    end
    bus.E_MDStart = 1'b1; bus.E_MDIsDiv = 1'b1;
    @(negedge clk);
    bus.E_MDStart = 1'b0;
    #1;
    num_checks++;
    if (bus.MD_Count !== 4'd10 || bus.MD_State !== 1'b1) begin
      num_fail++; $display("FAIL b2b_reload: count=%0d state=%b expected 10 1", bus.MD_Count, bus.MD_State);
    end
    // Req while busy does not stop the countdown.
    bus.Req = 1'b1;
    @(negedge clk);
    bus.Req = 1'b0;
    #1;
    num_checks++;
    if (bus.MD_Count !== 4'd9) begin
      num_fail++; $display("FAIL req_while_busy: got %0d expected 9", bus.MD_Count);
    end
    // Run down to 7, then async reset mid-count.
    @(negedge clk);
    @(negedge clk);
    #1;
    num_checks++;
    if (bus.MD_Count !== 4'd7) begin
      num_fail++; $display("FAIL div_at_7: got %0d expected 7", bus.MD_Count);
    end
    reset_n = 1'b0;
    #1;
    num_checks++;
    if (bus.MD_Count !== 4'd0 || bus.MD_Busy !== 1'b0) begin
      num_fail++; $display("FAIL async_reset: count=%0d busy=%b expected 0 0", bus.MD_Count, bus.MD_Busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    drive_idle();
    bus.E_RegWrite = 1'b1; bus.E_A3 = 5'd8; bus.E_Tnew = 2'd2;
    bus.D_Rs = 5'd8; bus.D_TuseRs = 2'd1;
    repeat (3) @(negedge clk);
    drive_idle();
    #1;
    num_checks++;
    if (bus.Perf_StallCnt !== 32'd3) begin
      num_fail++; $display("FAIL perf_count: got %0d expected 3", bus.Perf_StallCnt);
    end
    force dut.r_perf_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_cnt;
    bus.E_RegWrite = 1'b1; bus.E_A3 = 5'd8; bus.E_Tnew = 2'd2;
    bus.D_Rs = 5'd8; bus.D_TuseRs = 2'd1;
    @(negedge clk);
    drive_idle();
    #1;
    num_checks++;
    if (bus.Perf_StallCnt !== 32'hFFFF_FFFF) begin
      num_fail++; $display("FAIL perf_saturate: got %h expected ffffffff", bus.Perf_StallCnt);
    end
  endtask
`endif

  initial begin
    num_checks = 0;
    num_fail   = 0;
    test_reset();
    test_data_hazard();
    test_zero_reg();
    test_mult_countdown();
    test_req_blocks_start();
    test_back_to_back();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
